usb_pkt_tx: RTL and testbench

Link-layer packet transmitter, the TX counterpart of the link receive path. It serialises token and handshake requests from the transaction layer into a byte stream for the packet layer (tx_lp_*). Token packets get PID, address and endpoint bytes plus a generated CRC5. Data packets stream through from tx_lt_*, and the block appends CRC16. The block sits between the transaction layer and the packet layer, alongside the link receiver.

---
 rtl/usb_pkg.sv | 45 ++++
 rtl/usb_crc16_byte.sv | 22 ++
 rtl/usb_pkt_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_usb_pkt_tx.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB link-layer definitions: PIDs, PID type codes, CRC constants, TX states.
package usb_pkg;

  // 4-bit PID codes (the wire byte is {~pid, pid})
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  // PID type field, pid[1:0]
  localparam logic [1:0] PID_TYPE_TOKEN     = 2'b01;
  localparam logic [1:0] PID_TYPE_DATA      = 2'b11;
  localparam logic [1:0] PID_TYPE_HANDSHAKE = 2'b10;

  // CRC5: x^5+x^2+1, shifted MSB-side
  localparam logic [4:0]  CRC5_POLY       = 5'b00101;
  localparam logic [4:0]  CRC5_RESIDUE    = 5'b01100;
  // CRC16: x^16+x^15+x^2+1, normal and reflected forms
  localparam logic [15:0] CRC16_POLY      = 16'h8005;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_RESIDUE   = 16'h800D;

  // State names describe which byte currently sits in the output register
  typedef enum logic [3:0] {
    StIdle,
    StTok0,
    StTok1,
    StTok2,
    StHs,
    StDpid,
    StData,
    StCrcl,
    StCrch
  } tx_state_e;

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// Combinational CRC16 update for one byte, reflected polynomial, LSB first.
module usb_crc16_byte
  import usb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  // Eight serial shift steps unrolled
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i]) begin
        crc_out = (crc_out >> 1) ^ CRC16_POLY_REFL;
      end else begin
        crc_out = crc_out >> 1;
      end
    end
  end

endmodule

// File: rtl/usb_pkt_tx.sv
// Link-layer packet transmitter: tokens, handshakes and data packets with CRC append.
module usb_pkt_tx
  import usb_pkg::*;
#(
  parameter logic [15:0] CRC16_INIT = 16'hFFFF,
  parameter logic [4:0]  CRC5_INIT  = 5'h1F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] tx_pid,
  input  logic [6:0] tx_addr,
  input  logic [3:0] tx_endp,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_lt_sop,
  input  logic       tx_lt_eop,
  input  logic       tx_lt_valid,
  input  logic [7:0] tx_lt_data,
  output logic       tx_lt_ready,
  input  logic       tx_lt_cancle,
  output logic       tx_lp_sop,
  output logic       tx_lp_eop,
  output logic       tx_lp_valid,
  output logic [7:0] tx_lp_data,
  input  logic       tx_lp_ready,
  output logic       tx_lp_cancle
);

  tx_state_e   state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic [3:0]  endp_q, endp_d;
  logic [15:0] crc16_q, crc16_d, crc16_nxt;
  logic        last_q, last_d;   // final payload byte is in the output register
  logic        zlp_q, zlp_d;     // PID byte carried eop
  logic        lp_sop_q, lp_sop_d, lp_eop_q, lp_eop_d, lp_valid_q, lp_valid_d;
  logic        lp_cancle_q, lp_cancle_d;
  logic [7:0]  lp_data_q, lp_data_d;
  logic [4:0]  crc5_acc, crc5;
  logic [10:0] tok_bits;
  logic        out_free, xfer, in_data_pkt;

  assign out_free    = !lp_valid_q || tx_lp_ready;
  assign xfer        = lp_valid_q && tx_lp_ready;
  assign in_data_pkt = (state_q == StDpid) || (state_q == StData) ||
                       (state_q == StCrcl) || (state_q == StCrch);
  assign tok_bits    = {endp_q, addr_q};

  assign tx_ready    = (state_q == StIdle);
  // rst_n gating keeps every output except tx_ready low while reset is held
  assign tx_lt_ready = rst_n && (((state_q == StIdle) && !tx_valid) ||
                                ((state_q == StData) && !last_q && out_free));

  assign tx_lp_sop    = lp_sop_q;
  assign tx_lp_eop    = lp_eop_q;
  assign tx_lp_valid  = lp_valid_q;
  assign tx_lp_data   = lp_data_q;
  assign tx_lp_cancle = lp_cancle_q;

  usb_crc16_byte u_crc16 (
    .crc_in  (crc16_q),
    .data    (tx_lt_data),
    .crc_out (crc16_nxt)
  );

  // CRC5 over {endp, addr} LSB first; complemented and bit-reversed into byte position
  always_comb begin
    crc5_acc = CRC5_INIT;
    for (int i = 0; i < 11; i++) begin
      if (crc5_acc[4] ^ tok_bits[i]) begin
        crc5_acc = {crc5_acc[3:0], 1'b0} ^ CRC5_POLY;
      end else begin
        crc5_acc = {crc5_acc[3:0], 1'b0};
      end
    end
    for (int i = 0; i < 5; i++) begin
      crc5[i] = ~crc5_acc[4-i];
    end
  end

  // Next-state and output-register load logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    endp_d      = endp_q;
    crc16_d     = crc16_q;
    last_d      = last_q;
    zlp_d       = zlp_q;
    lp_sop_d    = lp_sop_q;
    lp_eop_d    = lp_eop_q;
    lp_valid_d  = lp_valid_q;
    lp_data_d   = lp_data_q;
    lp_cancle_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          addr_d     = tx_addr;
          endp_d     = tx_endp;
          lp_data_d  = pid_byte(tx_pid);
          lp_valid_d = 1'b1;
          lp_sop_d   = 1'b1;
          if (tx_pid[1:0] == PID_TYPE_TOKEN) begin
            lp_eop_d = 1'b0;
            state_d  = StTok0;
          end else begin
            lp_eop_d = 1'b1;
            state_d  = StHs;
          end
        end else if (tx_lt_valid && tx_lt_sop) begin
          lp_data_d  = tx_lt_data;
          lp_valid_d = 1'b1;
          lp_sop_d   = 1'b1;
          lp_eop_d   = 1'b0;
          zlp_d      = tx_lt_eop;
          last_d     = 1'b0;
          crc16_d    = CRC16_INIT;
          state_d    = StDpid;
        end
      end
      StTok0: begin
        if (xfer) begin
          lp_data_d = {endp_q[0], addr_q};
          lp_sop_d  = 1'b0;
          state_d   = StTok1;
        end
      end
      StTok1: begin
        if (xfer) begin
          lp_data_d = {crc5, endp_q[3:1]};
          lp_eop_d  = 1'b1;
          state_d   = StTok2;
        end
      end
      StTok2, StHs, StCrch: begin
        if (xfer) begin
          lp_valid_d = 1'b0;
          lp_sop_d   = 1'b0;
          lp_eop_d   = 1'b0;
          state_d    = StIdle;
        end
      end
      StDpid: begin
        if (xfer) begin
          lp_sop_d = 1'b0;
          if (zlp_q) begin
            lp_data_d = ~crc16_q[7:0];
            state_d   = StCrcl;
          end else begin
            lp_valid_d = 1'b0;
            state_d    = StData;
          end
        end
      end
      StData: begin
        if (tx_lt_valid && tx_lt_ready) begin
          lp_data_d  = tx_lt_data;
          lp_valid_d = 1'b1;
          lp_sop_d   = 1'b0;
          lp_eop_d   = 1'b0;
          crc16_d    = crc16_nxt;
          last_d     = tx_lt_eop;
        end else if (last_q && xfer) begin
          lp_data_d = ~crc16_q[7:0];
          state_d   = StCrcl;
        end else if (xfer) begin
          lp_valid_d = 1'b0;
        end
      end
      StCrcl: begin
        if (xfer) begin
          lp_data_d = ~crc16_q[15:8];
          lp_eop_d  = 1'b1;
          state_d   = StCrch;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over any byte movement in the data path
    if (tx_lt_cancle && in_data_pkt) begin
      lp_valid_d  = 1'b0;
      lp_sop_d    = 1'b0;
      lp_eop_d    = 1'b0;
      lp_cancle_d = 1'b1;
      crc16_d     = CRC16_INIT;
      last_d      = 1'b0;
      zlp_d       = 1'b0;
      state_d     = StIdle;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      endp_q      <= '0;
      crc16_q     <= CRC16_INIT;
      last_q      <= 1'b0;
      zlp_q       <= 1'b0;
      lp_sop_q    <= 1'b0;
      lp_eop_q    <= 1'b0;
      lp_valid_q  <= 1'b0;
      lp_data_q   <= '0;
      lp_cancle_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      endp_q      <= endp_d;
      crc16_q     <= crc16_d;
      last_q      <= last_d;
      zlp_q       <= zlp_d;
      lp_sop_q    <= lp_sop_d;
      lp_eop_q    <= lp_eop_d;
      lp_valid_q  <= lp_valid_d;
      lp_data_q   <= lp_data_d;
      lp_cancle_q <= lp_cancle_d;
    end
  end

endmodule

// File: tb/tb_usb_pkt_tx.sv
// Directed bench for usb_pkt_tx: tokens, handshakes, data CRC16, cancel, arbitration, reset.
module tb_usb_pkt_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] tx_pid;
  logic [6:0] tx_addr;
  logic [3:0] tx_endp;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_lt_sop, tx_lt_eop, tx_lt_valid;
  logic [7:0] tx_lt_data;
  logic       tx_lt_ready;
  logic       tx_lt_cancle;
  logic       tx_lp_sop, tx_lp_eop, tx_lp_valid;
  logic [7:0] tx_lp_data;
  logic       tx_lp_ready;
  logic       tx_lp_cancle;

  int errors = 0;
  int checks = 0;

  logic [9:0] got_q[$];   // {sop, eop, data}
  logic [9:0] exp_q[$];
  logic [7:0] lt_arr[16];
  bit         bp = 1'b0;
  bit         xfer_flag = 1'b0;
  int         stall_err = 0;
  int         stall_cycles = 0;

  always #5 clk = ~clk;

  usb_pkt_tx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_pid       (tx_pid),
    .tx_addr      (tx_addr),
    .tx_endp      (tx_endp),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_lt_sop    (tx_lt_sop),
    .tx_lt_eop    (tx_lt_eop),
    .tx_lt_valid  (tx_lt_valid),
    .tx_lt_data   (tx_lt_data),
    .tx_lt_ready  (tx_lt_ready),
    .tx_lt_cancle (tx_lt_cancle),
    .tx_lp_sop    (tx_lp_sop),
    .tx_lp_eop    (tx_lp_eop),
    .tx_lp_valid  (tx_lp_valid),
    .tx_lp_data   (tx_lp_data),
    .tx_lp_ready  (tx_lp_ready),
    .tx_lp_cancle (tx_lp_cancle)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Record transfers and check output stability while stalled (sampled at negedge)
  initial begin
    logic [9:0] held;
    bit         hold_v;
    hold_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (rst_n && tx_lp_valid && tx_lp_ready) begin
        got_q.push_back({tx_lp_sop, tx_lp_eop, tx_lp_data});
        xfer_flag = 1'b1;
        hold_v    = 1'b0;
      end else if (rst_n && tx_lp_valid && !tx_lp_ready) begin
        stall_cycles++;
        if (hold_v && held != {tx_lp_sop, tx_lp_eop, tx_lp_data}) stall_err++;
        held   = {tx_lp_sop, tx_lp_eop, tx_lp_data};
        hold_v = 1'b1;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // Packet-layer ready: always high, or 32 low cycles after every transfer when bp is set
  initial begin
    int cnt;
    cnt = 0;
    tx_lp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!bp) begin
        tx_lp_ready = 1'b1;
        cnt = 0;
        xfer_flag = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        tx_lp_ready = (cnt == 0);
      end else if (xfer_flag) begin
        xfer_flag = 1'b0;
        tx_lp_ready = 1'b0;
        cnt = 32;
      end
    end
  end

  task automatic add_exp(input logic [7:0] b, input bit s, input bit e);
    exp_q.push_back({s, e, b});
  endtask

  task automatic send_tok(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp);
    int c;
    tx_pid = pid; tx_addr = addr; tx_endp = endp; tx_valid = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!tx_ready && c < 2000);
    if (!tx_ready) check_eq("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic send_lt(input int n, input bit with_eop);
    int c;
    for (int i = 0; i < n; i++) begin
      tx_lt_valid = 1'b1;
      tx_lt_data  = lt_arr[i];
      tx_lt_sop   = (i == 0);
      tx_lt_eop   = with_eop && (i == n - 1);
      c = 0;
      do begin @(negedge clk); c++; end while (!tx_lt_ready && c < 2000);
      if (!tx_lt_ready) check_eq("lt_ready_wait", {31'd0, tx_lt_ready}, 32'd1);
      @(posedge clk); #1;
    end
    tx_lt_valid = 1'b0; tx_lt_sop = 1'b0; tx_lt_eop = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (got_q.size() < exp_q.size() && c < 3000) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_pkt(input string tag);
    int n;
    check_eq($sformatf("%s_len", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s[%0d]", tag, i), {22'd0, got_q[i]}, {22'd0, exp_q[i]});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Data packet: PID C3 followed by the payload already in lt_arr[1..n-1]
  task automatic data_pkt(input string tag, input int n, input logic [7:0] lo,
                          input logic [7:0] hi);
    add_exp(8'hC3, 1'b1, 1'b0);
    for (int i = 1; i < n; i++) add_exp(lt_arr[i], 1'b0, 1'b0);
    add_exp(lo, 1'b0, 1'b0);
    add_exp(hi, 1'b0, 1'b1);
    send_lt(n, 1'b1);
    wait_done();
    check_pkt(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    tx_pid = '0; tx_addr = '0; tx_endp = '0; tx_valid = 1'b0;
    tx_lt_sop = 1'b0; tx_lt_eop = 1'b0; tx_lt_valid = 1'b0; tx_lt_data = '0;
    tx_lt_cancle = 1'b0;

    // Reset values
    #3;
    check_eq("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check_eq("rst_lp_valid", {31'd0, tx_lp_valid}, 32'd0);
    check_eq("rst_lp_sop", {31'd0, tx_lp_sop}, 32'd0);
    check_eq("rst_lp_eop", {31'd0, tx_lp_eop}, 32'd0);
    check_eq("rst_lp_data", {24'd0, tx_lp_data}, 32'd0);
    check_eq("rst_lp_cancle", {31'd0, tx_lp_cancle}, 32'd0);
    check_eq("rst_lt_ready", {31'd0, tx_lt_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Tokens
    add_exp(8'h69, 1'b1, 1'b0); add_exp(8'h08, 1'b0, 1'b0); add_exp(8'h60, 1'b0, 1'b1);
    send_tok(4'b1001, 7'h08, 4'h0);
    wait_done();
    check_pkt("tok_in");
    add_exp(8'hE1, 1'b1, 1'b0); add_exp(8'h08, 1'b0, 1'b0); add_exp(8'h60, 1'b0, 1'b1);
    send_tok(4'b0001, 7'h08, 4'h0);
    wait_done();
    check_pkt("tok_out");

    // Handshakes
    add_exp(8'hD2, 1'b1, 1'b1);
    send_tok(4'b0010, 7'h00, 4'h0);
    wait_done();
    check_pkt("hs_ack");
    add_exp(8'h5A, 1'b1, 1'b1);
    send_tok(4'b1010, 7'h00, 4'h0);
    wait_done();
    check_pkt("hs_nak");

    // Data with 32-cycle backpressure after every transfer
    lt_arr[0] = 8'hC3;
    for (int i = 1; i <= 5; i++) lt_arr[i] = 8'(i);
    bp = 1'b1;
    data_pkt("data_bp", 6, 8'hD5, 8'h44);
    bp = 1'b0;
    check_eq("stall_hold_errs", stall_err, 0);
    check_eq("stalls_seen", {31'd0, stall_cycles > 100}, 32'd1);

    for (int i = 1; i <= 5; i++) lt_arr[i] = 8'(i + 2);
    data_pkt("data_03_07", 6, 8'hCC, 8'hAC);
    for (int i = 1; i <= 7; i++) lt_arr[i] = 8'(i);
    data_pkt("data_01_07", 8, 8'hE2, 8'h8E);

    // Zero-length DATA0
    add_exp(8'hC3, 1'b1, 1'b0); add_exp(8'h00, 1'b0, 1'b0); add_exp(8'h00, 1'b0, 1'b1);
    send_lt(1, 1'b1);
    wait_done();
    check_pkt("zlp");

    // Cancel after two payload bytes
    lt_arr[1] = 8'h01; lt_arr[2] = 8'h02;
    send_lt(3, 1'b0);
    tx_lt_cancle = 1'b1;
    @(posedge clk); #1;
    tx_lt_cancle = 1'b0;
    @(negedge clk);
    check_eq("cancel_pulse", {31'd0, tx_lp_cancle}, 32'd1);
    check_eq("cancel_valid", {31'd0, tx_lp_valid}, 32'd0);
    check_eq("cancel_tx_ready", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    check_eq("cancel_pulse_end", {31'd0, tx_lp_cancle}, 32'd0);
    @(posedge clk); #1;
    got_q.delete();
    for (int i = 1; i <= 5; i++) lt_arr[i] = 8'(i);
    data_pkt("after_cancel", 6, 8'hD5, 8'h44);

    // Arbitration: token and data sop in the same cycle
    tx_pid = 4'b1001; tx_addr = 7'h08; tx_endp = 4'h0; tx_valid = 1'b1;
    tx_lt_valid = 1'b1; tx_lt_sop = 1'b1; tx_lt_eop = 1'b1; tx_lt_data = 8'hC3;
    @(negedge clk);
    check_eq("arb_lt_ready_idle", {31'd0, tx_lt_ready}, 32'd0);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("arb_lt_ready_tok%0d", k), {31'd0, tx_lt_ready}, 32'd0);
      @(posedge clk); #1;
    end
    begin
      int c;
      c = 0;
      do begin @(negedge clk); c++; end while (!tx_lt_ready && c < 100);
      check_eq("arb_lt_accept", {31'd0, tx_lt_ready}, 32'd1);
      @(posedge clk); #1;
    end
    tx_lt_valid = 1'b0; tx_lt_sop = 1'b0; tx_lt_eop = 1'b0;
    add_exp(8'h69, 1'b1, 1'b0); add_exp(8'h08, 1'b0, 1'b0); add_exp(8'h60, 1'b0, 1'b1);
    add_exp(8'hC3, 1'b1, 1'b0); add_exp(8'h00, 1'b0, 1'b0); add_exp(8'h00, 1'b0, 1'b1);
    wait_done();
    check_pkt("arb");

    // Asynchronous reset in the middle of a token
    send_tok(4'b1001, 7'h08, 4'h0);
    check_eq("mid_tok_valid", {31'd0, tx_lp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, tx_lp_valid}, 32'd0);
    check_eq("mid_rst_sop", {31'd0, tx_lp_sop}, 32'd0);
    check_eq("mid_rst_data", {24'd0, tx_lp_data}, 32'd0);
    check_eq("mid_rst_cancle", {31'd0, tx_lp_cancle}, 32'd0);
    check_eq("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    got_q.delete();
    @(posedge clk); #1;
    add_exp(8'hD2, 1'b1, 1'b1);
    send_tok(4'b0010, 7'h00, 4'h0);
    wait_done();
    check_pkt("post_rst_ack");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
